// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues word fetches under a credit limit,
// and buffers in-order responses as {pc, data} entries for the decode stage.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [31:0]   tag_q  [DEPTH];

    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] tag_rd_ptr, tag_rd_ptr_nxt, tag_wr_ptr, tag_wr_ptr_nxt;
    logic [CW-1:0] count, count_nxt, live, live_nxt, discard, discard_nxt;
    logic          run_q;
    logic [SW-1:0] credits_used;
    logic          accept, pop, resp_keep, resp_drop;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Every outstanding request, kept or doomed, holds one FIFO slot until it resolves.
    assign credits_used   = SW'(count) + SW'(live) + SW'(discard);
    assign imem_req_valid = run_q && !redirect_valid && (credits_used < SW'(DEPTH));
    assign imem_addr      = fetch_pc;
    assign inst_valid     = (count != '0) && !redirect_valid;
    assign inst_data      = fifo_q[rd_ptr].data;
    assign inst_pc        = fifo_q[rd_ptr].pc;

    assign accept    = imem_req_valid && imem_req_ready;
    assign pop       = inst_valid && inst_ready;
    assign resp_drop = imem_resp_valid && (discard != '0);
    assign resp_keep = imem_resp_valid && (discard == '0) && (live != '0);

    // Next-state logic; a redirect flushes everything and re-targets the fetch PC.
    always_comb begin
        fetch_pc_nxt   = fetch_pc;
        rd_ptr_nxt     = rd_ptr;
        wr_ptr_nxt     = wr_ptr;
        tag_rd_ptr_nxt = tag_rd_ptr;
        tag_wr_ptr_nxt = tag_wr_ptr;
        count_nxt      = count;
        live_nxt       = live;
        discard_nxt    = discard;
        if (redirect_valid) begin
            fetch_pc_nxt   = {redirect_pc[31:2], 2'b00};
            rd_ptr_nxt     = '0;
            wr_ptr_nxt     = '0;
            tag_rd_ptr_nxt = '0;
            tag_wr_ptr_nxt = '0;
            count_nxt      = '0;
            live_nxt       = '0;
            discard_nxt    = discard + live
                           - CW'(imem_resp_valid && ((discard != '0) || (live != '0)));
        end else begin
            if (accept) begin
                fetch_pc_nxt   = fetch_pc + 32'd4;
                tag_wr_ptr_nxt = tag_wr_ptr + PW'(1);
            end
            if (resp_keep) begin
                wr_ptr_nxt     = wr_ptr + PW'(1);
                tag_rd_ptr_nxt = tag_rd_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr_nxt = rd_ptr + PW'(1);
            end
            live_nxt    = live + CW'(accept) - CW'(resp_keep);
            discard_nxt = discard - CW'(resp_drop);
            count_nxt   = count + CW'(resp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc   <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            tag_rd_ptr <= '0;
            tag_wr_ptr <= '0;
            count      <= '0;
            live       <= '0;
            discard    <= '0;
        end else begin
            run_q      <= 1'b1;
            fetch_pc   <= fetch_pc_nxt;
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= wr_ptr_nxt;
            tag_rd_ptr <= tag_rd_ptr_nxt;
            tag_wr_ptr <= tag_wr_ptr_nxt;
            count      <= count_nxt;
            live       <= live_nxt;
            discard    <= discard_nxt;
        end
    end

    // Tag FIFO remembers issued addresses; data FIFO pairs them with returned words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (!redirect_valid) begin
            if (accept) begin
                tag_q[tag_wr_ptr] <= fetch_pc;
            end
            if (resp_keep) begin
                fifo_q[wr_ptr] <= '{pc: tag_q[tag_rd_ptr], data: imem_resp_data};
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue: a queue-based memory and fetch model
// predicts requests, credit stalls, flushes and delivered {pc, data} each cycle.
module tb_inst_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct { logic [31:0] addr; int unsigned epoch; int unsigned due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;

    req_t        memq[$];
    inst_t       expq[$];
    logic [31:0] exp_fetch;
    int unsigned epoch, cyc;
    bit          up;
    int unsigned tests, fails;
    int unsigned lat_min, lat_max, p_ready, p_iready, p_redir;
    bit          force_redir;
    logic [31:0] force_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        tests++;
        fails++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic drive_inputs();
        imem_req_ready = ($urandom_range(99) < p_ready);
        inst_ready     = ($urandom_range(99) < p_iready);
        redirect_valid = ($urandom_range(99) < p_redir);
        redirect_pc    = $urandom();
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end
        if (memq.size() > 0 && cyc >= memq[0].due) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(memq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom();
        end
    endtask

    // One clock: drive, compare against the model mid-cycle, then advance the model.
    task automatic cycle();
        bit    exp_req, exp_iv, keep;
        req_t  r;
        drive_inputs();
        @(negedge clk);
        exp_req = up && !redirect_valid && (expq.size() + memq.size() < DEPTH);
        exp_iv  = (expq.size() > 0) && !redirect_valid;
        check("imem_req_valid", 32'(imem_req_valid), 32'(exp_req));
        check("imem_addr", imem_addr, exp_fetch);
        check("inst_valid", 32'(inst_valid), 32'(exp_iv));
        if (exp_iv) begin
            check("inst_pc", inst_pc, expq[0].pc);
            check("inst_data", inst_data, expq[0].data);
        end
        @(posedge clk);
        #1;
        keep = 1'b0;
        if (imem_resp_valid) begin
            r    = memq.pop_front();
            keep = !redirect_valid && (r.epoch == epoch);
        end
        if (redirect_valid) begin
            expq.delete();
            epoch++;
            exp_fetch = {redirect_pc[31:2], 2'b00};
        end else begin
            if (exp_iv && inst_ready) void'(expq.pop_front());
            if (keep) expq.push_back('{pc: r.addr, data: mem_word(r.addr)});
            if (exp_req && imem_req_ready) begin
                memq.push_back('{addr: exp_fetch, epoch: epoch,
                                 due: cyc + $urandom_range(lat_max, lat_min)});
                exp_fetch += 32'd4;
            end
        end
        up = 1'b1;
        cyc++;
    endtask

    task automatic model_reset();
        memq.delete();
        expq.delete();
        exp_fetch = RESET_PC;
        up = 1'b0;
        epoch++;
    endtask

    initial begin
        bit done;
        tests = 0; fails = 0; epoch = 0; cyc = 0; force_redir = 1'b0; force_pc = '0;
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        model_reset();
        #12;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full throughput, 1-cycle memory, addresses wrap past 0xFFFF_FFFC.
        lat_min = 1; lat_max = 1; p_ready = 100; p_iready = 100; p_redir = 0;
        repeat (20) cycle();

        // Stalled consumer: issue stops at DEPTH credits, then drains in order.
        p_iready = 0;
        repeat (10) cycle();
        #1;
        check("stall_no_req", 32'(imem_req_valid), 32'd0);
        check("stall_inst_valid", 32'(inst_valid), 32'd1);
        p_iready = 100;
        repeat (10) cycle();

        // Latency 3 with requests in flight, redirect to an unaligned target.
        lat_min = 3; lat_max = 3;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = (memq.size() >= 2);
        end
        if (!done) timeout("inflight_wait");
        force_redir = 1'b1; force_pc = 32'h0000_0103;
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = (expq.size() > 0);
        end
        if (!done) timeout("redir_first_inst");
        #1;
        check("redir_first_valid", 32'(inst_valid), 32'd1);
        check("redir_first_pc", inst_pc, 32'h0000_0100);

        // Random traffic: variable latency, backpressure, redirects incl. same-cycle responses.
        lat_min = 1; lat_max = 5; p_ready = 70; p_iready = 60; p_redir = 6;
        repeat (3000) cycle();

        // Fill exactly three entries, then pulse reset asynchronously.
        lat_min = 1; lat_max = 1; p_iready = 0; p_redir = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            p_ready = (expq.size() + memq.size() < 3) ? 100 : 0;
            cycle();
            done = (expq.size() == 3) && (memq.size() == 0);
        end
        if (!done) timeout("fill_three");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_inst_valid", 32'(inst_valid), 32'd0);
        check("async_req_valid", 32'(imem_req_valid), 32'd0);
        check("async_imem_addr", imem_addr, RESET_PC);
        model_reset();
        imem_resp_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        p_ready = 100; p_iready = 100;
        repeat (12) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $fatal(1, "FAIL global_timeout observed=timeout expected=finish");
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end that owns the program counter, issues word fetches to a variable-latency instruction memory, and buffers returned words in an in-order FIFO. Sits directly upstream of the instruction decode/execute datapath: it supplies one instruction plus its PC per valid/ready handshake, and accepts branch/jump redirects back from that datapath. Redirects flush the queue and discard any in-flight stale responses.

## Interface
- DEPTH, 4, FIFO entries and in-flight request cap; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_addr  output  32  word-aligned fetch address
- imem_resp_valid  input  1  response data valid; responses return in request order, ≥1 cycle after acceptance
- imem_resp_data  input  32  fetched instruction word
- inst_valid  output  1  head entry valid toward datapath
- inst_ready  input  1  datapath consumes head entry
- inst_data  output  32  head instruction word
- inst_pc  output  32  address of head instruction
- redirect_valid  input  1  branch/jump taken; flush and refetch
- redirect_pc  input  32  new fetch address; bits [1:0] ignored, forced 0

## Operation
- State: fetch_pc (32), FIFO of {pc, data} × DEPTH, count, live (outstanding requests whose responses are kept), discard (outstanding requests whose responses are dropped); counters clog2(DEPTH)+1 bits.
- Reset (rst_n low, async): fetch_pc=RESET_PC, count=0, live=0, discard=0, FIFO pointers 0. Outputs during reset: imem_req_valid=0, inst_valid=0, imem_addr=RESET_PC, inst_data/inst_pc=0.
- Issue: imem_req_valid = !redirect_valid && (count + live + discard < DEPTH). imem_addr = fetch_pc. On accept (valid & ready): fetch_pc += 4 (mod 2^32, 0xFFFF_FFFC wraps to 0), live += 1. A separate in-order PC tag FIFO (depth DEPTH) records each issued address.
- Response: if discard > 0, response dropped and discard -= 1; else if live > 0, {tag pc, data} pushed into FIFO, live -= 1; response with live=discard=0 is a protocol violation and is ignored.
- Output: inst_valid = (count > 0) && !redirect_valid; inst_data/inst_pc = head entry. Pop on inst_valid & inst_ready.
- Simultaneous push and pop: count unchanged. Credit rule guarantees push never hits a full FIFO.
- Redirect (priority over everything): next cycle count=0, FIFO and tag pointers reset, fetch_pc = {redirect_pc[31:2],2'b00}, discard = discard + live − (imem_resp_valid ? 1 : 0), live=0. A response arriving in the redirect cycle is dropped. No request issued and no pop in the redirect cycle.
- Back-to-back redirects: each one overrides; the last one's PC wins, discard accumulates correctly.

## Timing
- Request for fetch_pc is presented the cycle after reset release.
- Response-to-inst_valid latency: 1 cycle (response registered into FIFO; inst_valid high the following cycle).
- Redirect-to-first-request latency: 1 cycle (imem_req_valid with imem_addr=redirect_pc the cycle after redirect_valid).
- Peak throughput: one instruction per cycle when memory accepts every cycle and latency ≤ DEPTH−1.
- Stalled consumer (inst_ready=0): issue stops once count + live + discard = DEPTH; resumes the cycle after a pop.
- Reset asserted mid-operation: all state cleared immediately; responses to pre-reset requests are the memory model's responsibility to squash.

## Test plan
- Reset release, memory ready every cycle, 1-cycle latency, inst_ready=1 -> addresses 0x0,0x4,0x8… issued on consecutive cycles; inst_pc 0x0,0x4,0x8… with matching data one per cycle.
- inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; count=4; on inst_ready=1 entries drain in order 0x0..0xC and issue resumes at 0x10.
- Memory latency 3, two requests in flight, redirect_valid with redirect_pc=0x0000_0103 -> next request addr 0x100; both stale responses dropped; first inst_pc=0x100.
- Response arriving in same cycle as redirect -> that response dropped, discard excludes it; no stale instruction appears on inst_pc.
- RESET_PC=0xFFFF_FFF8 -> issued addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- rst_n pulsed low with FIFO holding 3 entries -> inst_valid=0 and imem_req_valid=0 asynchronously; after release, first request at RESET_PC.
